// File: rtl/frontend_backend_fifo_pkg.sv
// Shared frontend/backend bundle types.
// The packet struct fixes the width of one queue entry.
package frontend_backend_fifo_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        rd_we;
  } frontend_packet_t;

  localparam int PACKET_WIDTH = $bits(frontend_packet_t);

endpackage

// File: rtl/frontend_backend_fifo_if.sv
// Push/pop handshake between frontend issue and backend execute.
// The master side is the frontend/backend pair; the slave is the queue.
interface frontend_backend_fifo_if
  import frontend_backend_fifo_pkg::*;
#(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             push_valid;
  frontend_packet_t push_packet;
  logic             full;
  logic             almost_full;
  logic             pop_ready;
  logic             pop_valid;
  frontend_packet_t pop_packet;
  logic             empty;
  logic [CW-1:0]    count;

  modport master (
    output push_valid, push_packet, pop_ready,
    input  full, almost_full, pop_valid,
    input  pop_packet, empty, count
  );

  modport slave (
    input  push_valid, push_packet, pop_ready,
    output full, almost_full, pop_valid,
    output pop_packet, empty, count
  );
endinterface

// File: rtl/frontend_backend_fifo_mem.sv
// Type-agnostic register array: one write port, one async read port.
// Contents are never reset; the control logic masks stale entries.
module frontend_backend_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/frontend_backend_fifo.sv
// Decoupling queue between frontend issue and backend execute.
// Single-cycle flush; full feeds the frontend backend_busy stall.
module frontend_backend_fifo
  import frontend_backend_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ALMOST_FULL_THRESH = DEPTH - 2
) (
  input logic clk,
  input logic rst,
  input logic flush,
  frontend_backend_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [PACKET_WIDTH-1:0] wdata;
  logic [PACKET_WIDTH-1:0] rdata;
  logic push_fire;
  logic pop_fire;
  logic mem_we;

  assign bus.full        = (count == CW'(DEPTH));
  assign bus.empty       = (count == '0);
  assign bus.pop_valid   = ~bus.empty;
  assign bus.almost_full = (count >= CW'(ALMOST_FULL_THRESH));
  assign bus.count       = count;

  assign push_fire = bus.push_valid & ~bus.full;
  assign pop_fire  = bus.pop_ready & bus.pop_valid;
  // A flushed packet must not land in storage.
  assign mem_we    = push_fire & ~flush & ~rst;
  assign wdata     = bus.push_packet;

  assign bus.pop_packet = bus.pop_valid
                        ? frontend_packet_t'(rdata)
                        : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  frontend_backend_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (PACKET_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  a_count_max: assert property (@(posedge clk) disable iff (rst)
    count <= CW'(DEPTH));
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push_fire && bus.full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    !(pop_fire && bus.empty));
  a_ptr_count: assert property (@(posedge clk) disable iff (rst)
    AW'(wr_ptr - rd_ptr) == count[AW-1:0]);
endmodule

// File: tb/tb_frontend_backend_fifo.sv
// Bench: vector table, hand sequences and random traffic,
// all checked against a queue-based scoreboard.
module tb_frontend_backend_fifo;
  import frontend_backend_fifo_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 0;
  logic rst;
  logic flush;

  frontend_backend_fifo_if #(.DEPTH(DEPTH)) bus ();

  frontend_backend_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  frontend_packet_t sb[$];
  logic [31:0] pc_next = 32'h8000_0000;

  typedef struct {
    bit pv;
    bit pr;
    bit fl;
    int exp_count;
    bit exp_full;
    bit exp_af;
    bit exp_empty;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [159:0] act,
                     input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic frontend_packet_t mk(input logic [31:0] pc);
    frontend_packet_t p;
    p.pc       = pc;
    p.instr    = $urandom;
    p.rs1_data = $urandom;
    p.rs2_data = $urandom;
    p.rd       = 5'($urandom);
    p.rd_we    = 1'($urandom);
    return p;
  endfunction

  // One clock: drive, update the model at the edge, check after it.
  task automatic cycle(input bit pv, input bit pr, input bit fl,
                       input bit r);
    frontend_packet_t p;
    bit push_ok;
    bit pop_ok;
    int n;
    p = mk(pc_next);
    bus.push_valid  = pv;
    bus.push_packet = p;
    bus.pop_ready   = pr;
    flush = fl;
    rst   = r;
    push_ok = pv && (sb.size() != DEPTH);
    pop_ok  = pr && (sb.size() != 0);
    @(posedge clk);
    if (r || fl) begin
      sb.delete();
    end else begin
      if (pop_ok) void'(sb.pop_front());
      if (push_ok) begin
        sb.push_back(p);
        pc_next += 32'd4;
      end
    end
    #1;
    n = sb.size();
    chk("count", 160'(bus.count), 160'(n));
    chk("empty", 160'(bus.empty), 160'(n == 0));
    chk("pop_valid", 160'(bus.pop_valid), 160'(n != 0));
    chk("full", 160'(bus.full), 160'(n == DEPTH));
    chk("almost_full", 160'(bus.almost_full), 160'(n >= DEPTH - 2));
    if (n == 0)
      chk("pop_packet_zero", 160'(bus.pop_packet), 160'(0));
    else
      chk("pop_packet", 160'(bus.pop_packet), 160'(sb[0]));
  endtask

  initial begin
    bus.push_valid  = 0;
    bus.push_packet = '0;
    bus.pop_ready   = 0;
    flush = 0;
    rst   = 1;

    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    chk("idle_count", 160'(bus.count), 160'(0));
    chk("idle_pkt", 160'(bus.pop_packet), 160'(0));

    for (int i = 1; i <= 8; i++)
      vecs.push_back('{1, 0, 0, i, i == 8, i >= 6, 0});
    vecs.push_back('{1, 0, 0, 8, 1, 1, 0});
    vecs.push_back('{1, 1, 0, 7, 0, 1, 0});
    vecs.push_back('{1, 0, 0, 8, 1, 1, 0});
    vecs.push_back('{0, 1, 0, 7, 0, 1, 0});
    vecs.push_back('{0, 1, 0, 6, 0, 1, 0});
    vecs.push_back('{0, 1, 0, 5, 0, 0, 0});
    vecs.push_back('{1, 1, 1, 0, 0, 0, 1});
    vecs.push_back('{1, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 1, 0, 0, 0, 0, 1});
    foreach (vecs[i]) begin
      cycle(vecs[i].pv, vecs[i].pr, vecs[i].fl, 0);
      chk($sformatf("vec%0d_count", i), 160'(bus.count),
          160'(vecs[i].exp_count));
      chk($sformatf("vec%0d_full", i), 160'(bus.full),
          160'(vecs[i].exp_full));
      chk($sformatf("vec%0d_af", i), 160'(bus.almost_full),
          160'(vecs[i].exp_af));
      chk($sformatf("vec%0d_empty", i), 160'(bus.empty),
          160'(vecs[i].exp_empty));
    end

    // Streaming: first pop visible one cycle after first push.
    cycle(1, 1, 0, 0);
    chk("stream_first_valid", 160'(bus.pop_valid), 160'(1));
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, 0, 0);
      chk("stream_count", 160'(bus.count), 160'(1));
    end
    cycle(0, 1, 0, 0);

    // Flush with five entries and concurrent push/pop.
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
    chk("pre_flush_count", 160'(bus.count), 160'(5));
    cycle(1, 1, 1, 0);
    chk("flush_count", 160'(bus.count), 160'(0));
    chk("flush_pkt", 160'(bus.pop_packet), 160'(0));
    cycle(1, 0, 0, 0);
    chk("post_flush_valid", 160'(bus.pop_valid), 160'(1));
    chk("post_flush_pc", 160'(bus.pop_packet.pc), 160'(pc_next - 4));

    for (int i = 0; i < 10000; i++) begin
      bit r;
      bit fl;
      r  = (i % 2500) == 1234;
      fl = ($urandom_range(0, 499) == 0);
      cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 55,
            fl, r);
      if (r) chk("mid_rst_count", 160'(bus.count), 160'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
